keypad_input_8b: RTL

- Upstream input stage of the 8-bit CPU.
- Scans a 4x4 matrix keypad, debounces presses and accumulates decimal digits into an 8-bit unsigned value.
- On ENTER it presents the value on VAL, which drives the CPU data-input selector, and pulses key_event into the program counter.
- Replaces the constant key_event tie-off and the bench-driven input value.

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/keypad_input_8b_scanner.sv | 145 ++++++++++++++
 rtl/keypad_input_8b.sv | 102 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad input stage:
//   - scan_state_t : scanner FSM state encoding (SCAN / DEBOUNCE / HELD)
//   - KEY_ENTER, KEY_CLEAR : key codes with special actions
//   - digit_t, key_to_digit() : maps a 4-bit key code (row*4 + col) to a
//     decimal digit plus a valid flag
//   - lowest_row() : index of the lowest set bit of a row sample
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  localparam logic [3:0] KEY_ENTER = 4'h3;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } digit_t;

  // Row-major key map:
  //   row 0: 1 2 3 A
  //   row 1: 4 5 6 B
  //   row 2: 7 8 9 C
  //   row 3: * 0 # D
  function automatic digit_t key_to_digit(input logic [3:0] code);
    digit_t d;
    d.valid = 1'b1;
    d.digit = 4'd0;
    case (code)
      4'h0: d.digit = 4'd1;
      4'h1: d.digit = 4'd2;
      4'h2: d.digit = 4'd3;
      4'h4: d.digit = 4'd4;
      4'h5: d.digit = 4'd5;
      4'h6: d.digit = 4'd6;
      4'h8: d.digit = 4'd7;
      4'h9: d.digit = 4'd8;
      4'hA: d.digit = 4'd9;
      4'hD: d.digit = 4'd0;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Lower row index wins when several rows are closed at once.
  function automatic logic [1:0] lowest_row(input logic [3:0] row);
    logic [1:0] r;
    if (row[0])      r = 2'd0;
    else if (row[1]) r = 2'd1;
    else if (row[2]) r = 2'd2;
    else             r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/keypad_input_8b_scanner.sv
// keypad_scanner
// Drives the keypad columns, synchronises the row inputs and runs the
// SCAN / DEBOUNCE / HELD state machine. Produces a single-cycle key_valid
// strobe on the edge a debounced press is committed.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   row       in   raw row sense (asynchronous to clk)
//   col       out  one-hot column drive
//   key_valid out  combinational commit strobe (acts on the current edge)
//   key_code  out  row*4 + col of the committed key, valid with key_valid
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  scan_state_t   state_reg, state_next;
  logic [3:0]    row_meta_reg, row_sync_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg, col_idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    code_reg, code_next;
  logic [3:0]    pat_reg, pat_next;

  logic          sample;
  logic [3:0]    detect_code;

  // The dwell counter free-runs; the column only moves on sample edges, so
  // a frozen column simply keeps sampling every SCAN_DIV cycles.
  assign sample      = (dwell_reg == DWELL_LAST);
  assign detect_code = {lowest_row(row_sync_reg), col_idx_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_reg <= 4'b0;
      row_sync_reg <= 4'b0;
      dwell_reg    <= '0;
      state_reg    <= ST_SCAN;
      col_idx_reg  <= 2'd0;
      cnt_reg      <= '0;
      code_reg     <= 4'h0;
      pat_reg      <= 4'h0;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      dwell_reg    <= sample ? '0 : dwell_reg + DW'(1);
      state_reg    <= state_next;
      col_idx_reg  <= col_idx_next;
      cnt_reg      <= cnt_next;
      code_reg     <= code_next;
      pat_reg      <= pat_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    cnt_next     = cnt_reg;
    code_next    = code_reg;
    pat_next     = pat_reg;
    key_valid    = 1'b0;
    key_code     = code_reg;

    if (sample) begin
      case (state_reg)
        ST_SCAN: begin
          if (row_sync_reg != 4'b0) begin
            code_next = detect_code;
            pat_next  = row_sync_reg;
            if (CNT_ONE == CNT_MAX) begin
              // Single-sample debounce: the detecting sample commits.
              key_valid  = 1'b1;
              key_code   = detect_code;
              state_next = ST_HELD;
              cnt_next   = '0;
            end else begin
              state_next = ST_DEBOUNCE;
              cnt_next   = CNT_ONE;
            end
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (row_sync_reg == pat_reg) begin
            if (cnt_reg + CW'(1) == CNT_MAX) begin
              key_valid  = 1'b1;
              state_next = ST_HELD;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end else begin
            state_next   = ST_SCAN;
            col_idx_next = col_idx_reg + 2'd1;
            cnt_next     = '0;
          end
        end

        ST_HELD: begin
          // Counts consecutive released samples; any closure restarts it.
          if (row_sync_reg == 4'b0) begin
            if (cnt_reg + CW'(1) == CNT_MAX) begin
              state_next   = ST_SCAN;
              col_idx_next = col_idx_reg + 2'd1;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end

        default: begin
          state_next = ST_SCAN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/keypad_input_8b.sv
// keypad_input_8b
// Keypad front end for the 8-bit CPU: scans a 4x4 keypad, accumulates
// decimal digits into an 8-bit saturating value and publishes it on ENTER.
// Ports:
//   CK        in   system clock
//   RST       in   asynchronous active-high reset
//   ROW       in   keypad row sense, active-high
//   COL       out  keypad column drive, one-hot
//   VAL       out  last entered value
//   key_event out  one-cycle pulse when VAL is updated
//   ACC       out  digit accumulator
//   OVF       out  accumulator saturated since last CLEAR/ENTER
module keypad_input_8b
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       CK,
  input  logic       RST,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [7:0] VAL,
  output logic       key_event,
  output logic [7:0] ACC,
  output logic       OVF
);

  logic       key_valid;
  logic [3:0] key_code;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) u_scanner (
    .clk      (CK),
    .rst      (RST),
    .row      (ROW),
    .col      (COL),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  logic [7:0]  acc_reg, acc_next;
  logic [7:0]  val_reg, val_next;
  logic        ovf_reg, ovf_next;
  logic        event_reg, event_next;

  digit_t      dig;
  logic [11:0] acc_ext;
  logic        clipped;

  // 255*10 + 9 = 2559 fits in 12 bits, so the product never wraps.
  assign dig     = key_to_digit(key_code);
  assign acc_ext = {4'b0, acc_reg} * 12'd10 + {8'b0, dig.digit};
  assign clipped = (acc_ext > 12'd255);

  always_comb begin
    acc_next   = acc_reg;
    val_next   = val_reg;
    ovf_next   = ovf_reg;
    event_next = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_ENTER) begin
        val_next   = acc_reg;
        event_next = 1'b1;
        acc_next   = 8'd0;
        ovf_next   = 1'b0;
      end else if (key_code == KEY_CLEAR) begin
        acc_next = 8'd0;
        ovf_next = 1'b0;
      end else if (dig.valid) begin
        if (ovf_reg || clipped) begin
          acc_next = 8'hFF;
          ovf_next = 1'b1;
        end else begin
          acc_next = acc_ext[7:0];
        end
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      acc_reg   <= 8'd0;
      val_reg   <= 8'd0;
      ovf_reg   <= 1'b0;
      event_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      val_reg   <= val_next;
      ovf_reg   <= ovf_next;
      event_reg <= event_next;
    end
  end

  assign ACC       = acc_reg;
  assign VAL       = val_reg;
  assign OVF       = ovf_reg;
  assign key_event = event_reg;

endmodule
